// File: rtl/n1_pbus_pkg.sv
// Shared types and constants for the N1 program-bus fetch engine.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package n1_pbus_pkg;

    // Fetch engine control state; the encoding is visible on the probe port.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    // Response kind after resolving simultaneous ack/err/rty.
    localparam logic [1:0] RESP_NONE = 2'd0;
    localparam logic [1:0] RESP_ACK  = 2'd1;
    localparam logic [1:0] RESP_RTY  = 2'd2;
    localparam logic [1:0] RESP_ERR  = 2'd3;

    // A slave asserting several response lines at once is resolved err > rty > ack.
    function automatic logic [1:0] resp_sel(input logic ack, input logic err, input logic rty);
        logic [1:0] kind;
        kind = RESP_NONE;
        if (err) begin
            kind = RESP_ERR;
        end else if (rty) begin
            kind = RESP_RTY;
        end else if (ack) begin
            kind = RESP_ACK;
        end
        return kind;
    endfunction

endpackage

// File: rtl/n1_fifo_sync.sv
// Synchronous FIFO with clear and occupancy count; head is shown combinationally.
// Latency: a pushed word is visible at head_o the cycle after the push.
// Backpressure: push when full and pop when empty are ignored; clear beats push and pop.
module n1_fifo_sync #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 33
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clr_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_dat_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q;
    logic [PW-1:0]    rd_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i && (cnt_q != CW'(DEPTH)) && !clr_i;
    assign do_pop  = pop_i && (cnt_q != '0) && !clr_i;

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (clr_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= wr_q + PW'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + PW'(1);
            end
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: entries are only read once counted valid.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_q] <= push_dat_i;
        end
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/n1_pbus_fetch.sv
// Pipelined Wishbone program fetch with prefetch FIFO, bounded retry, error tokens and flush.
// Latency: restart to first request 1 cycle; ack to fetch_rdy_o 1 cycle.
// Backpressure: requests issue only while in-flight plus buffered words fit the FIFO.
module n1_pbus_fetch
    import n1_pbus_pkg::*;
#(
    parameter int ADR_WIDTH = 16,
    parameter int DAT_WIDTH = 16,
    parameter int DEPTH     = 4,
    parameter int RTY_MAX   = 3
) (
    input  logic                         clk_i,
    input  logic                         async_rst_i,
    output logic                         pbus_cyc_o,
    output logic                         pbus_stb_o,
    output logic [ADR_WIDTH-1:0]         pbus_adr_o,
    input  logic [DAT_WIDTH-1:0]         pbus_dat_i,
    input  logic                         pbus_ack_i,
    input  logic                         pbus_err_i,
    input  logic                         pbus_rty_i,
    input  logic                         pbus_stall_i,
    input  logic                         fetch_start_i,
    input  logic [ADR_WIDTH-1:0]         fetch_adr_i,
    input  logic                         fetch_pop_i,
    output logic                         fetch_rdy_o,
    output logic [DAT_WIDTH-1:0]         fetch_dat_o,
    output logic [ADR_WIDTH-1:0]         fetch_adr_o,
    output logic                         fetch_err_o,
    output logic [1:0]                   prb_state_o,
    output logic [$clog2(DEPTH+1)-1:0]   prb_inflight_o
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int RW = (RTY_MAX < 1) ? 1 : $clog2(RTY_MAX+1);
    localparam logic [CW:0]   CRED_MAX = (CW+1)'(DEPTH);
    localparam logic [RW-1:0] RTY_LIM  = RW'(RTY_MAX);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_RUN  = ST_RUN;
    localparam logic [1:0] S_HALT = ST_HALT;

    // One prefetch slot: error flag, the word's address and its data.
    typedef struct packed {
        logic                 err;
        logic [ADR_WIDTH-1:0] adr;
        logic [DAT_WIDTH-1:0] dat;
    } ent_t;

    logic [1:0]           state_q, state_d;
    logic [ADR_WIDTH-1:0] next_adr_q, next_adr_d;
    logic [CW-1:0]        inflight_q, inflight_d;
    logic [CW-1:0]        discard_q, discard_d;
    logic [RW-1:0]        rty_q, rty_d;

    logic [CW-1:0]        fifo_cnt;
    ent_t                 head_ent;
    ent_t                 push_ent;
    logic                 push;
    logic                 pop;
    logic                 stb;
    logic                 accept;
    logic [1:0]           resp_code;
    logic                 resp;
    logic                 err_evt;
    logic [ADR_WIDTH-1:0] oldest_adr;

    // Every outstanding request and every buffered word holds a FIFO slot, so overflow is impossible.
    assign stb        = (state_q == S_RUN) &&
                        (({1'b0, inflight_q} + {1'b0, fifo_cnt}) < CRED_MAX);
    assign accept     = stb && !pbus_stall_i;
    assign resp_code  = (inflight_q != '0) ? resp_sel(pbus_ack_i, pbus_err_i, pbus_rty_i)
                                           : RESP_NONE;
    assign resp       = (resp_code != RESP_NONE);
    assign oldest_adr = next_adr_q - ADR_WIDTH'(inflight_q);
    assign pop        = fetch_pop_i && (fifo_cnt != '0) && !fetch_start_i;

    // Next-state: request issue, in-order retirement, retry rewind, error halt, restart.
    always_comb begin
        state_d    = state_q;
        next_adr_d = accept ? next_adr_q + ADR_WIDTH'(1) : next_adr_q;
        inflight_d = inflight_q + CW'(accept) - CW'(resp);
        discard_d  = discard_q;
        rty_d      = rty_q;
        push       = 1'b0;
        push_ent   = '0;
        err_evt    = 1'b0;

        if (resp && !fetch_start_i) begin
            if (discard_q != '0) begin
                discard_d = discard_q - CW'(1);
            end else begin
                case (resp_code)
                    RESP_ACK: begin
                        push         = 1'b1;
                        push_ent.adr = oldest_adr;
                        push_ent.dat = pbus_dat_i;
                        rty_d        = '0;
                    end
                    RESP_RTY: begin
                        if (rty_q < RTY_LIM) begin
                            // Rewind to the retried word; everything newer is already stale.
                            rty_d      = rty_q + RW'(1);
                            next_adr_d = oldest_adr;
                            discard_d  = inflight_d;
                        end else begin
                            err_evt = 1'b1;
                        end
                    end
                    default: begin
                        err_evt = 1'b1;
                    end
                endcase
            end
        end

        if (err_evt) begin
            push         = 1'b1;
            push_ent.err = 1'b1;
            push_ent.adr = oldest_adr;
            discard_d    = inflight_d;
            rty_d        = '0;
            state_d      = S_HALT;
        end

        // Restart wins over everything: all still-owed responses become stale.
        if (fetch_start_i) begin
            push       = 1'b0;
            state_d    = S_RUN;
            next_adr_d = fetch_adr_i;
            discard_d  = inflight_d;
            rty_d      = '0;
        end
    end

    // Control registers.
    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            state_q    <= S_IDLE;
            next_adr_q <= '0;
            inflight_q <= '0;
            discard_q  <= '0;
            rty_q      <= '0;
        end else begin
            state_q    <= state_d;
            next_adr_q <= next_adr_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            rty_q      <= rty_d;
        end
    end

    n1_fifo_sync #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(ent_t))
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (async_rst_i),
        .clr_i      (fetch_start_i),
        .push_i     (push),
        .push_dat_i (push_ent),
        .pop_i      (pop),
        .head_o     (head_ent),
        .count_o    (fifo_cnt)
    );

    assign pbus_stb_o     = stb;
    assign pbus_cyc_o     = stb || (inflight_q != '0);
    assign pbus_adr_o     = next_adr_q;
    assign fetch_rdy_o    = (fifo_cnt != '0);
    assign fetch_dat_o    = fetch_rdy_o ? head_ent.dat : '0;
    assign fetch_adr_o    = fetch_rdy_o ? head_ent.adr : '0;
    assign fetch_err_o    = fetch_rdy_o && head_ent.err;
    assign prb_state_o    = state_q;
    assign prb_inflight_o = inflight_q;

endmodule
